// File: rtl/f2h_sdram_read_arbiter.sv
// f2h_sdram_read_arbiter
// Shares one Avalon-MM burst read port between a high-priority display reader
// (m0) and a secondary reader (m1). Grants are registered (one command per two
// cycles at best), m1 is guaranteed a slot after STARVE_LIMIT back-to-back m0
// grants, and a small FIFO of outstanding bursts steers each returning beat to
// the master that issued it.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | no master granted; arbitrate if tracking FIFO has room
// S_GRANT0| m0 drives the slave command bus until accepted or read drops
// S_GRANT1| m1 drives the slave command bus until accepted or read drops

module f2h_sdram_read_arbiter #(
   parameter int DATA_WIDTH      = 256,
   parameter int ADDR_WIDTH      = 27,
   parameter int BURST_WIDTH     = 8,
   parameter int MAX_OUTSTANDING = 4,
   parameter int STARVE_LIMIT    = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [ADDR_WIDTH-1:0]  m0_address,
   input  logic [BURST_WIDTH-1:0] m0_burstcount,
   input  logic                   m0_read,
   output logic                   m0_waitrequest,
   output logic [DATA_WIDTH-1:0]  m0_readdata,
   output logic                   m0_readdatavalid,
   input  logic [ADDR_WIDTH-1:0]  m1_address,
   input  logic [BURST_WIDTH-1:0] m1_burstcount,
   input  logic                   m1_read,
   output logic                   m1_waitrequest,
   output logic [DATA_WIDTH-1:0]  m1_readdata,
   output logic                   m1_readdatavalid,
   output logic [ADDR_WIDTH-1:0]  s_address,
   output logic [BURST_WIDTH-1:0] s_burstcount,
   output logic                   s_read,
   input  logic                   s_waitrequest,
   input  logic [DATA_WIDTH-1:0]  s_readdata,
   input  logic                   s_readdatavalid,
   output logic                   protocol_err_o
);

   localparam int PW = $clog2(MAX_OUTSTANDING);
   localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] MAX_CNT    = CW'(MAX_OUTSTANDING);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_GRANT0 = 2'd1,
      S_GRANT1 = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]          count_q, count_d;
   logic [BURST_WIDTH-1:0] beat_q, beat_d;
   logic [SW-1:0]          starve_q, starve_d;
   logic                   err_q, err_d;

   logic                   fifo_id_q [MAX_OUTSTANDING];
   logic [BURST_WIDTH-1:0] fifo_bc_q [MAX_OUTSTANDING];

   logic                   g_active, g_sel1, g_read, bc_zero, accept;
   logic [ADDR_WIDTH-1:0]  g_addr;
   logic [BURST_WIDTH-1:0] g_bc, beat_inc, head_bc;
   logic                   fifo_empty, head_id, beat_fire, pop;

   // Granted master's command view; an all-zero burstcount never reaches the slave.
   always_comb begin
      g_active = (state_q != S_IDLE);
      g_sel1   = (state_q == S_GRANT1);
      g_read   = g_sel1 ? m1_read       : m0_read;
      g_addr   = g_sel1 ? m1_address    : m0_address;
      g_bc     = g_sel1 ? m1_burstcount : m0_burstcount;
      bc_zero  = (g_bc == '0);

      s_read       = g_active & g_read & ~bc_zero;
      s_address    = g_active ? g_addr : '0;
      s_burstcount = g_active ? g_bc   : '0;
      accept       = s_read & ~s_waitrequest;

      m0_waitrequest = ((state_q == S_GRANT0) && !bc_zero) ? s_waitrequest : 1'b1;
      m1_waitrequest = ((state_q == S_GRANT1) && !bc_zero) ? s_waitrequest : 1'b1;
   end

   // Response steering from the head of the outstanding-burst FIFO.
   always_comb begin
      fifo_empty = (count_q == '0);
      head_id    = fifo_id_q[rd_ptr_q];
      head_bc    = fifo_bc_q[rd_ptr_q];
      beat_fire  = s_readdatavalid & ~fifo_empty;
      beat_inc   = beat_q + 1'b1;
      pop        = beat_fire & (beat_inc == head_bc);

      m0_readdatavalid = beat_fire & ~head_id;
      m1_readdatavalid = beat_fire &  head_id;
      m0_readdata      = s_readdata;
      m1_readdata      = s_readdata;
      protocol_err_o   = err_q;
   end

   // Next-state: arbitration, FIFO bookkeeping, starvation and error tracking.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            // Full test uses the registered count, so a same-cycle pop does not help.
            if (count_q < MAX_CNT) begin
               if (m1_read && (!m0_read || starve_q == STARVE_MAX)) state_d = S_GRANT1;
               else if (m0_read)                                    state_d = S_GRANT0;
            end
         end
         S_GRANT0, S_GRANT1: begin
            if (accept || !g_read) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      wr_ptr_d = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop    ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      if (accept && !pop)      count_d = count_q + 1'b1;
      else if (!accept && pop) count_d = count_q - 1'b1;

      beat_d = beat_q;
      if (beat_fire) beat_d = pop ? '0 : beat_inc;

      starve_d = starve_q;
      if (accept && !g_sel1 && m1_read && starve_q != STARVE_MAX) starve_d = starve_q + 1'b1;
      else if (accept && g_sel1)                                   starve_d = '0;
      else if (!g_active && !m1_read)                              starve_d = '0;

      err_d = err_q
            | (g_active & ~g_read)
            | (g_active & bc_zero)
            | (s_readdatavalid & fifo_empty);
   end

   // Control registers; reset discards every outstanding burst.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         beat_q   <= '0;
         starve_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         beat_q   <= beat_d;
         starve_q <= starve_d;
         err_q    <= err_d;
      end
   end

   // FIFO storage; entries are only read while count_q marks them valid.
   always_ff @(posedge clk) begin
      if (accept) begin
         fifo_id_q[wr_ptr_q] <= g_sel1;
         fifo_bc_q[wr_ptr_q] <= g_bc;
      end
   end

endmodule

// File: doc/f2h_sdram_read_arbiter.md
Name: f2h_sdram_read_arbiter

Overview:
Shares the single FPGA-to-HPS SDRAM Avalon-MM read port between two burst read masters. m0 is the display path (sdram_reader, high priority). m1 is a secondary reader (capture/DMA/test). The block handles registered grant arbitration with an anti-starvation limit, tracks outstanding pipelined bursts, and routes each readdatavalid beat back to the master that issued the burst. It sits between the readers and the f2h_sdram port of the soc_system, in the 50 MHz fabric domain.

Parameters:
DATA_WIDTH, 256, readdata width
ADDR_WIDTH, 27, word address width
BURST_WIDTH, 8, burstcount width
MAX_OUTSTANDING, 4, depth of the burst tracking FIFO (power of 2)
STARVE_LIMIT, 8, consecutive m0 grants allowed while m1 waits

Ports:
clk  in  1  fabric clock
rst_n  in  1  asynchronous active-low reset
m0_address / m1_address  in  ADDR_WIDTH  master read address
m0_burstcount / m1_burstcount  in  BURST_WIDTH  beats per burst, 1..2^BURST_WIDTH-1
m0_read / m1_read  in  1  read request; held until accepted
m0_waitrequest / m1_waitrequest  out  1  command stall to master
m0_readdata / m1_readdata  out  DATA_WIDTH  broadcast of s_readdata
m0_readdatavalid / m1_readdatavalid  out  1  beat valid, routed per owner
s_address  out  ADDR_WIDTH  to f2h_sdram
s_burstcount  out  BURST_WIDTH  to f2h_sdram
s_read  out  1  to f2h_sdram
s_waitrequest  in  1  from f2h_sdram
s_readdata  in  DATA_WIDTH  from f2h_sdram
s_readdatavalid  in  1  from f2h_sdram
protocol_err_o  out  1  sticky error flag, cleared only by reset

Behaviour:
- Reset values:
  - State IDLE, FIFO empty, beat counter 0, starve_cnt 0, protocol_err_o 0.
  - s_read 0; s_address and s_burstcount 0.
  - Both waitrequests 1; both readdatavalids 0.
- FSM states: IDLE, GRANT0, GRANT1.
- IDLE:
  - Arbitrates only if fifo_count < MAX_OUTSTANDING, using the registered count.
  - Winner is m1 if m1_read and (!m0_read or starve_cnt == STARVE_LIMIT); else m0 if m0_read.
  - Moves to GRANTx on the next edge. No s_read is issued in IDLE.
- GRANTx:
  - s_read, s_address and s_burstcount combinationally follow mx.
  - mx_waitrequest = s_waitrequest; the other master's waitrequest = 1.
  - Acceptance is s_read & !s_waitrequest. On acceptance: push {id=x, burstcount} into the FIFO and return to IDLE.
  - Command latency: request in IDLE at cycle N; s_read at N+1; at most one command per 2 cycles.
  - If mx_read drops while granted (protocol violation), return to IDLE and set protocol_err_o.
- Burstcount 0 in a granted cycle: s_read forced 0, mx_waitrequest held 1, protocol_err_o set, and the FSM stays in GRANTx until mx_read drops.
- Starvation counter:
  - starve_cnt increments on each m0 acceptance while m1_read is high, saturating at STARVE_LIMIT.
  - It clears on any m1 acceptance, or when m1_read is low in IDLE.
- Response routing:
  - The FIFO head gives the owner id and beat count.
  - On s_readdatavalid, the owner's readdatavalid is asserted in the same cycle (combinational); readdata is broadcast to both masters.
  - The beat counter increments per beat. On beat == head burstcount it resets to 0 and the FIFO pops.
- s_readdatavalid with an empty FIFO: no master readdatavalid, protocol_err_o set.
- Same-cycle push and pop are both performed; the count is unchanged.
- Full check uses the count at the start of the cycle, so a pop in the same cycle does not unblock arbitration until the next cycle.
- Reset mid-burst: all tracking is discarded. Stray beats returned after reset are flagged by protocol_err_o and not routed.
- All registers are on the clk edge with rst_n async clear; there is no combinational path from s_readdatavalid to any s_* output.

Test Plan:
- Single m0 burst, addr 0x100, bc 8, s_waitrequest 0: s_read high exactly 1 cycle, 1 cycle after m0_read. 8 beats on m0_readdatavalid only; FIFO empty afterwards.
- m0 and m1 both requesting continuously, bc 4, STARVE_LIMIT 8: acceptance order is m0 ×8 then m1 ×1, repeating. m1 data beats never appear on m0.
- Interleaved outstanding: m0 bc 2 then m1 bc 3 accepted before any data. 5 beats returned: first 2 go to m0, next 3 go to m1.
- FIFO full: 4 accepted bursts with no data returned. A fifth request sees waitrequest 1 and s_read 0. After the last beat of the first burst, the fifth command is issued within 3 cycles.
- s_waitrequest held 1 for 5 cycles in GRANT0: s_address and s_burstcount stable, m1_waitrequest 1 throughout, acceptance on the cycle waitrequest falls.
- Errors: bc 0 on m1 sets protocol_err_o with no s_read. Reset low mid-burst, release, 2 stray beats: no master readdatavalid, protocol_err_o = 1, and the next m0 burst completes normally.
